// File: rtl/fifo_wr_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_wr_arbiter_if
//  Brief    : Bundle of producer request/data/ack and fifo write-port signals
//             shared by the round-robin fifo write arbiter.
//  Revision : 1.0  initial release
// ============================================================================
interface fifo_wr_arbiter_if #(
    parameter int D_W   = 8,
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
);
    logic [N_REQ-1:0]     req;
    logic [N_REQ*D_W-1:0] req_data;
    logic [N_REQ-1:0]     ack;
    logic                 fifo_full;
    logic                 fifo_write;
    logic [D_W-1:0]       fifo_data;
    logic                 grant_valid;
    logic [ID_W-1:0]      grant_id;

    // Producers plus fifo side: drive requests, data and the full flag
    modport master (
        output req, req_data, fifo_full,
        input  ack, fifo_write, fifo_data, grant_valid, grant_id
    );

    // Arbiter side
    modport slave (
        input  req, req_data, fifo_full,
        output ack, fifo_write, fifo_data, grant_valid, grant_id
    );
endinterface
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_wr_arbiter
//  Brief    : Round-robin arbiter sharing one fifo write port between N_REQ
//             producers. A grant lasts up to MAX_BURST accepted words, ends
//             early when the owner drops its request, and re-arbitrates in the
//             same edge so no idle cycle separates consecutive grants.
//  Revision : 1.0  initial release
// ============================================================================
module fifo_wr_arbiter #(
    parameter int D_W       = 8,
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 4,
    parameter int ID_W      = 2
) (
    input  wire logic        clk,
    input  wire logic        rst,     // asynchronous, active low
    fifo_wr_arbiter_if.slave bus
);

    localparam int                c_BC_W       = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [c_BC_W-1:0] c_BURST_LAST = c_BC_W'(MAX_BURST - 1);
    localparam logic [N_REQ-1:0]  c_ONE_HOT0   = N_REQ'(1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t             r_state;
    logic [ID_W-1:0]    r_owner;
    logic [ID_W-1:0]    r_ptr;
    logic [c_BC_W-1:0]  r_burst;

    logic               w_granted;
    logic               w_req_own;
    logic               w_write;
    logic               w_release;
    logic [ID_W-1:0]    w_base;
    logic [ID_W-1:0]    w_idx;
    logic [ID_W-1:0]    w_winner;
    logic               w_found;

    assign w_granted = (r_state == S_GRANT);
    assign w_req_own = bus.req[r_owner];
    assign w_write   = w_granted & w_req_own & ~bus.fifo_full;

    // A dropped request only releases when the fifo is not full, so a stall
    // never loses the grant.
    assign w_release = w_granted &
                       ((w_write & (r_burst == c_BURST_LAST)) |
                        (~w_req_own & ~bus.fifo_full));

    // On release the search starts just after the old owner (the new pointer),
    // which leaves the old owner with lowest priority; when idle it starts at ptr.
    // N_REQ is a power of two, so ID_W-bit arithmetic wraps modulo N_REQ.
    assign w_base = w_granted ? (r_owner + ID_W'(1)) : r_ptr;

    // Priority search from w_base; walking offsets downward lets the smallest
    // offset with a request be the last (winning) assignment.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            w_idx = w_base + ID_W'(i);
            if (bus.req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    assign bus.fifo_write  = w_write;
    assign bus.ack         = w_write ? (c_ONE_HOT0 << r_owner) : '0;
    assign bus.fifo_data   = w_granted ? bus.req_data[r_owner*D_W +: D_W] : '0;
    assign bus.grant_valid = w_granted;
    assign bus.grant_id    = r_owner;

    // Grant state machine: arbitration, burst counting and pointer rotation
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_owner <= '0;
            r_ptr   <= '0;
            r_burst <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_state <= S_GRANT;
                        r_owner <= w_winner;
                        r_burst <= '0;
                    end
                end
                S_GRANT: begin
                    if (w_release) begin
                        r_ptr   <= r_owner + ID_W'(1);
                        r_burst <= '0;
                        if (w_found) begin
                            r_owner <= w_winner;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else if (w_write) begin
                        r_burst <= r_burst + c_BC_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_wr_arbiter
//  Brief    : Self-checking bench for fifo_wr_arbiter: directed phases plus
//             randomized producers/full flag against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fifo_wr_arbiter;

    localparam int D_W  = 8;
    localparam int N    = 4;
    localparam int MB   = 4;
    localparam int ID_W = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.D_W(D_W), .N_REQ(N), .ID_W(ID_W)) bus ();

    fifo_wr_arbiter #(
        .D_W       (D_W),
        .N_REQ     (N),
        .MAX_BURST (MB),
        .ID_W      (ID_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_chk = 0;
    int n_bad = 0;

    // Reference model state (abstract: who owns, how many words, where next)
    int m_gv, m_own, m_cnt, m_ptr;

    // Stimulus state
    logic [N-1:0] rq;
    logic         full_r;
    logic [7:0]   seq [N];
    int           mode;      // request policy
    int           fullpol;   // 0 never full, 1 always full, 2 random
    int           cnt2;
    int           obs_ack2;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int search(input int base, input logic [N-1:0] r);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (base + k) % N;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    task automatic drive();
        bus.req       = rq;
        bus.fifo_full = full_r;
        for (int i = 0; i < N; i++) bus.req_data[i*D_W +: D_W] = seq[i];
    endtask

    // Producer behaviour after an edge: acked words advance, requests follow mode
    task automatic apply(input logic [N-1:0] a);
        for (int i = 0; i < N; i++) if (a[i]) seq[i] = seq[i] + 8'd1;
        case (mode)
            0: begin
                for (int i = 0; i < N; i++) begin
                    if (rq[i] && a[i])       rq[i] = ($urandom_range(0, 2) != 0);
                    else if (!rq[i])         rq[i] = ($urandom_range(0, 2) == 0);
                end
            end
            1: rq = 4'b1111;
            2: rq = 4'b1000;
            3: rq = 4'b0010;
            4: begin
                if (a[2]) cnt2++;
                rq[3] = 1'b1;
                rq[2] = (cnt2 < 2);
            end
            5: rq = 4'b0001;
            default: rq = 4'b0000;
        endcase
        case (fullpol)
            1:       full_r = 1'b1;
            2:       full_r = ($urandom_range(0, 3) == 0);
            default: full_r = 1'b0;
        endcase
        drive();
    endtask

    // One clock cycle: check outputs against the model, then advance both
    task automatic cycle();
        logic         e_w;
        logic [N-1:0] e_ack;
        logic [7:0]   e_data;
        int           w;
        int           n_gv, n_own, n_cnt, n_ptr;
        @(negedge clk);
        e_w    = (m_gv == 1) && rq[m_own] && !full_r;
        e_ack  = e_w ? (4'b0001 << m_own) : 4'b0000;
        e_data = (m_gv == 1) ? seq[m_own] : 8'h00;
        chk("write", 64'(bus.fifo_write), 64'(e_w));
        chk("ack",   64'(bus.ack),        64'(e_ack));
        chk("data",  64'(bus.fifo_data),  64'(e_data));
        chk("gvalid",64'(bus.grant_valid),64'(m_gv));
        if (m_gv == 1) chk("gid", 64'(bus.grant_id), 64'(m_own));
        if (bus.ack[2]) obs_ack2++;
        n_gv = m_gv; n_own = m_own; n_cnt = m_cnt; n_ptr = m_ptr;
        if (m_gv == 0) begin
            w = search(m_ptr, rq);
            if (w >= 0) begin n_gv = 1; n_own = w; n_cnt = 0; end
        end else if ((e_w && m_cnt == MB - 1) || (!rq[m_own] && !full_r)) begin
            n_ptr = (m_own + 1) % N;
            w = search(n_ptr, rq);
            n_cnt = 0;
            if (w >= 0) n_own = w;
            else        n_gv  = 0;
        end else if (e_w) begin
            n_cnt = m_cnt + 1;
        end
        @(posedge clk);
        #1;
        m_gv = n_gv; m_own = n_own; m_cnt = n_cnt; m_ptr = n_ptr;
        apply(e_ack);
    endtask

    task automatic run(input int m, input int fp, input int n);
        mode    = m;
        fullpol = fp;
        repeat (n) cycle();
    endtask

    // Reset asserted between edges: outputs must clear with no clock edge
    task automatic async_reset();
        @(negedge clk);
        #2;
        chk("pre_arst_gvalid", 64'(bus.grant_valid), 64'(m_gv));
        rst = 1'b0;
        #1;
        chk("arst_write",  64'(bus.fifo_write),  64'd0);
        chk("arst_ack",    64'(bus.ack),         64'd0);
        chk("arst_gvalid", 64'(bus.grant_valid), 64'd0);
        m_gv = 0; m_own = 0; m_cnt = 0; m_ptr = 0;
        @(posedge clk);
        #1;
        chk("arst_gid", 64'(bus.grant_id), 64'd0);
        rst = 1'b1;
    endtask

    initial begin
        m_gv = 0; m_own = 0; m_cnt = 0; m_ptr = 0;
        for (int i = 0; i < N; i++) seq[i] = 8'(i * 64);
        seq[0]   = 8'd1;
        rq       = 4'b0001;
        full_r   = 1'b0;
        mode     = 5;
        fullpol  = 0;
        cnt2     = 0;
        obs_ack2 = 0;
        rst      = 1'b0;
        drive();

        // Reset state while a request is already pending
        #12;
        chk("rst_gvalid", 64'(bus.grant_valid), 64'd0);
        chk("rst_gid",    64'(bus.grant_id),    64'd0);
        chk("rst_write",  64'(bus.fifo_write),  64'd0);
        chk("rst_ack",    64'(bus.ack),         64'd0);
        chk("rst_data",   64'(bus.fifo_data),   64'd0);
        #6;
        rst = 1'b1;

        // Single requester 0: bursts of 4 with a same-edge re-grant
        run(5, 0, 12);
        // All requesters: 0,1,2,3,0 rotation, 4 words each
        run(1, 0, 40);
        // Drain to idle, then requester 2 drops after 2 words while 3 waits
        run(6, 0, 3);
        cnt2     = 0;
        obs_ack2 = 0;
        rq       = 4'b1100;
        drive();
        run(4, 0, 14);
        chk("early_words2", 64'(obs_ack2), 64'd2);
        // Full stall on requester 1
        run(6, 0, 3);
        run(3, 0, 4);
        run(3, 1, 10);
        run(3, 0, 6);
        // Sole requester 3 re-wins back-to-back
        run(2, 0, 20);
        // Asynchronous reset in the middle of a burst
        run(1, 0, 8);
        async_reset();
        run(1, 0, 8);
        // Randomized producers and full flag
        run(0, 2, 2000);
        run(0, 0, 300);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
